// File: rtl/universal_register_pkg.sv
// Shared constants for the universal register.
//   MODE_W            : width of the operation-select field
//   MODE_HOLD..DEC    : operation encodings; all eight values are defined
package universal_register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/universal_register_input_capture_stage.sv
// Optional one-deep capture of the external control/data inputs.
//   clk_i, rst_ni            : clock, async active-low clear
//   enable_i/mode_i/d_i/ser_in_i : raw inputs from pins/switches
//   enable_o/mode_o/d_o/ser_in_o : captured (IN_REG=1) or pass-through (IN_REG=0)
module input_capture_stage
  import universal_register_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit IN_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              ser_in_i,
  output logic              enable_o,
  output logic [MODE_W-1:0] mode_o,
  output logic [WIDTH-1:0]  d_o,
  output logic              ser_in_o
);

  generate
    if (IN_REG) begin : g_reg
      logic              enable_q;
      logic [MODE_W-1:0] mode_q;
      logic [WIDTH-1:0]  d_q;
      logic              ser_in_q;

      // Clearing enable_q on reset is what discards any operation that was
      // in flight when reset hit.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          enable_q <= 1'b0;
          mode_q   <= MODE_HOLD;
          d_q      <= '0;
          ser_in_q <= 1'b0;
        end else begin
          enable_q <= enable_i;
          mode_q   <= mode_i;
          d_q      <= d_i;
          ser_in_q <= ser_in_i;
        end
      end

      assign enable_o = enable_q;
      assign mode_o   = mode_q;
      assign d_o      = d_q;
      assign ser_in_o = ser_in_q;
    end else begin : g_pass
      assign enable_o = enable_i;
      assign mode_o   = mode_i;
      assign d_o      = d_i;
      assign ser_in_o = ser_in_i;
    end
  endgenerate

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit register with hold/load/shift/rotate/increment/decrement.
//   clk_i, rst_ni : clock, async active-low reset (q_o <= RESET_VAL, carry_o <= 0)
//   enable_i      : 0 holds q_o and carry_o regardless of mode_i
//   mode_i        : operation select (see universal_register_pkg)
//   d_i           : parallel load data
//   ser_in_i      : fill bit for SHL/SHR
//   q_o           : register contents
//   carry_o       : registered shift-out / carry / borrow
//   zero_o        : combinational, q_o == 0
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               IN_REG    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              ser_in_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic              enable_r;
  logic [MODE_W-1:0] mode_r;
  logic [WIDTH-1:0]  d_r;
  logic              ser_in_r;

  input_capture_stage #(
    .WIDTH  (WIDTH),
    .IN_REG (IN_REG)
  ) u_capture (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .mode_i   (mode_i),
    .d_i      (d_i),
    .ser_in_i (ser_in_i),
    .enable_o (enable_r),
    .mode_o   (mode_r),
    .d_o      (d_r),
    .ser_in_o (ser_in_r)
  );

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   inc_w, dec_w;

  // One extra bit so the wrap-around shows up as the MSB: carry on
  // all-ones + 1, borrow on 0 - 1.
  assign inc_w = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (enable_r) begin
      case (mode_r)
        MODE_HOLD: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        MODE_LOAD: begin
          q_d     = d_r;
          carry_d = 1'b0;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], ser_in_r};
          carry_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d     = {ser_in_r, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        MODE_ROTL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        MODE_ROTR: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        MODE_INC: begin
          q_d     = inc_w[WIDTH-1:0];
          carry_d = inc_w[WIDTH];
        end
        MODE_DEC: begin
          q_d     = dec_w[WIDTH-1:0];
          carry_d = dec_w[WIDTH];
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = carry_q;
  assign zero_o  = (q_q == '0);

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;
  import universal_register_pkg::*;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [MODE_W-1:0] mode;
  logic [W-1:0]      d;
  logic              ser_in;

  logic [W-1:0] qa, qb;
  logic         ca, cb, za, zb;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // A: registered inputs, reset to 0. B: direct inputs, reset to 8'h5A.
  universal_register #(.WIDTH(W), .IN_REG(1'b1), .RESET_VAL(8'h00)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mode_i(mode),
    .d_i(d), .ser_in_i(ser_in), .q_o(qa), .carry_o(ca), .zero_o(za)
  );

  universal_register #(.WIDTH(W), .IN_REG(1'b0), .RESET_VAL(8'h5A)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mode_i(mode),
    .d_i(d), .ser_in_i(ser_in), .q_o(qb), .carry_o(cb), .zero_o(zb)
  );

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic en, input logic [MODE_W-1:0] m,
                      input logic [W-1:0] dv, input logic s);
    @(negedge clk);
    enable = en;
    mode   = m;
    d      = dv;
    ser_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] q_obs, input logic c_obs, input logic z_obs,
                     input logic [W-1:0] q_exp, input logic c_exp, input logic z_exp);
    tests++;
    assert ({q_obs, c_obs, z_obs} === {q_exp, c_exp, z_exp})
    else begin
      failed++;
      $error("FAIL %s: got q=%h carry=%b zero=%b, expected q=%h carry=%b zero=%b",
             tag, q_obs, c_obs, z_obs, q_exp, c_exp, z_exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = MODE_HOLD;
    d      = '0;
    ser_in = 1'b0;
    #23;
    chk("a_reset", qa, ca, za, 8'h00, 1'b0, 1'b1);
    chk("b_reset", qb, cb, zb, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD with one extra cycle of input latency
    step(1'b1, MODE_LOAD, 8'hA5, 1'b0);
    chk("a_load_latency", qa, ca, za, 8'h00, 1'b0, 1'b1);
    step(1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a_load", qa, ca, za, 8'hA5, 1'b0, 1'b0);

    // SHL from 81 with zero fill
    step(1'b1, MODE_LOAD, 8'h81, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0);
    chk("a_load81", qa, ca, za, 8'h81, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0);
    chk("a_shl1", qa, ca, za, 8'h02, 1'b1, 1'b0);
    step(1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a_shl2", qa, ca, za, 8'h04, 1'b0, 1'b0);

    // SHR with one fill
    step(1'b1, MODE_LOAD, 8'h01, 1'b0);
    step(1'b1, MODE_SHR, 8'h00, 1'b1);
    step(1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a_shr_fill1", qa, ca, za, 8'h80, 1'b1, 1'b0);

    // ROTR then ROTL from 01
    step(1'b1, MODE_LOAD, 8'h01, 1'b0);
    step(1'b1, MODE_ROTR, 8'h00, 1'b0);
    step(1'b1, MODE_ROTL, 8'h00, 1'b0);
    chk("a_rotr", qa, ca, za, 8'h80, 1'b1, 1'b0);
    step(1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a_rotl", qa, ca, za, 8'h01, 1'b1, 1'b0);

    // INC across the wrap, then DEC back across it
    step(1'b1, MODE_LOAD, 8'hFE, 1'b0);
    step(1'b1, MODE_INC, 8'h00, 1'b0);
    step(1'b1, MODE_INC, 8'h00, 1'b0);
    chk("a_inc_fe", qa, ca, za, 8'hFF, 1'b0, 1'b0);
    step(1'b1, MODE_DEC, 8'h00, 1'b0);
    chk("a_inc_wrap", qa, ca, za, 8'h00, 1'b1, 1'b1);
    step(1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a_dec_wrap", qa, ca, za, 8'hFF, 1'b1, 1'b0);

    // enable=0 freezes q and carry even with INC selected
    step(1'b1, MODE_LOAD, 8'h3C, 1'b0);
    step(1'b0, MODE_INC, 8'h00, 1'b0);
    chk("a_load3c", qa, ca, za, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, MODE_INC, 8'h00, 1'b0);
      chk($sformatf("a_hold_en0_%0d", i), qa, ca, za, 8'h3C, 1'b0, 1'b0);
    end

    // Arm an INC in the capture stage, then reset between edges
    step(1'b1, MODE_INC, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_reset", qa, ca, za, 8'h00, 1'b0, 1'b1);
    enable = 1'b0;
    mode   = MODE_HOLD;
    @(negedge clk);
    rst_n = 1'b1;
    // The armed INC must not survive reset
    step(1'b0, MODE_HOLD, 8'h00, 1'b0);
    chk("a_inflight_dropped", qa, ca, za, 8'h00, 1'b0, 1'b1);
    step(1'b0, MODE_HOLD, 8'h00, 1'b0);
    chk("a_still_zero", qa, ca, za, 8'h00, 1'b0, 1'b1);

    // Direct-input instance: reset value and zero-latency ops
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("b_reset_5a", qb, cb, zb, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, MODE_LOAD, 8'hA5, 1'b0);
    chk("b_load_first_edge", qb, cb, zb, 8'hA5, 1'b0, 1'b0);
    step(1'b1, MODE_LOAD, 8'h81, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0);
    chk("b_shl1", qb, cb, zb, 8'h02, 1'b1, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0);
    chk("b_shl2", qb, cb, zb, 8'h04, 1'b0, 1'b0);
    step(1'b1, MODE_DEC, 8'h00, 1'b0);
    chk("b_dec", qb, cb, zb, 8'h03, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
